// File: rtl/ram_reg.sv
// 512 x 32 word-addressed main memory with a registered read port feeding BusMuxIn.
// Read-first on a same-address read/write; reset clears only the output register.
module ram_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 9,
    parameter int DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] Data_Signal,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [31:0]           Address_Signal,
    output logic [DATA_WIDTH-1:0] BusMuxIn
);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_bus;
    logic [ADDR_BITS-1:0]  w_addr;
    logic                  w_addr_hi_unused;

    // Upper address bits alias onto the low ones, so they are deliberately dropped.
    assign w_addr           = Address_Signal[ADDR_BITS-1:0];
    assign w_addr_hi_unused = ^Address_Signal[31:ADDR_BITS];

    // Storage is not reset, so writes still land while clr is held low.
    always_ff @(posedge clk) begin
        if (Write) begin
            r_mem[w_addr] <= Data_Signal;
        end
    end

    // Non-blocking read of r_mem gives the old word on a same-address collision.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_bus <= '0;
        end else if (Read) begin
            r_bus <= r_mem[w_addr];
        end
    end

    assign BusMuxIn = r_bus;

endmodule

// File: tb/tb_ram_reg.sv
// Self-checking bench for ram_reg: directed vector table, reset and sweep sequences,
// then random traffic against an array-based memory model.
module tb_ram_reg;

    logic        clk;
    logic        clr;
    logic [31:0] Data_Signal;
    logic        Read;
    logic        Write;
    logic [31:0] Address_Signal;
    logic [31:0] BusMuxIn;

    int checks;
    int errors;

    logic [31:0] ref_mem [0:511];
    bit          ref_vld [0:511];
    logic [31:0] exp_bus;
    bit          exp_known;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [12];

    ram_reg #(
        .DATA_WIDTH(32),
        .ADDR_BITS (9),
        .DEPTH     (512)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .Data_Signal   (Data_Signal),
        .Read          (Read),
        .Write         (Write),
        .Address_Signal(Address_Signal),
        .BusMuxIn      (BusMuxIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one operation, let one rising edge sample it, then advance the model.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit chk, input string name);
        int idx;
        Read           = rd;
        Write          = wr;
        Address_Signal = addr;
        Data_Signal    = data;
        @(posedge clk);
        #1;
        idx = int'(addr % 32'd512);
        if (!clr) begin
            exp_bus   = 32'h0;
            exp_known = 1'b1;
        end else if (rd) begin
            exp_known = ref_vld[idx];
            exp_bus   = ref_mem[idx];
        end
        if (wr) begin
            ref_mem[idx] = data;
            ref_vld[idx] = 1'b1;
        end
        if (chk && exp_known) check(name, BusMuxIn, exp_bus);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_bus   = 32'h0;
        exp_known = 1'b1;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = 32'h0;
            ref_vld[i] = 1'b0;
        end

        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, "wr0_no_read"};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, "rd0"};
        tbl[2]  = '{1'b0, 1'b0, 32'h0000_0005, 32'h0,         32'h1234_5678, "hold1"};
        tbl[3]  = '{1'b0, 1'b0, 32'h0000_0005, 32'h0,         32'h1234_5678, "hold2"};
        tbl[4]  = '{1'b0, 1'b0, 32'h0000_0005, 32'h0,         32'h1234_5678, "hold3"};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_0203, 32'hDEAD_BEEF, 32'h1234_5678, "alias_wr"};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_0003, 32'h0,         32'hDEAD_BEEF, "alias_rd"};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 32'hDEAD_BEEF, "coll_pre"};
        tbl[8]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h2222_2222, 32'h1111_1111, "coll_old"};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h2222_2222, "coll_new"};
        tbl[10] = '{1'b1, 1'b0, 32'hFFFF_FE00, 32'h0,         32'h1234_5678, "alias_hi"};
        tbl[11] = '{1'b0, 1'b1, 32'h0000_01FF, 32'h5A5A_5A5A, 32'h1234_5678, "wr_top"};

        clr            = 1'b0;
        Read           = 1'b0;
        Write          = 1'b0;
        Address_Signal = 32'h0;
        Data_Signal    = 32'h0;
        #2;
        check("reset_state", BusMuxIn, 32'h0);
        #10;
        clr = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, 1'b0, tbl[i].name);
            check(tbl[i].name, BusMuxIn, tbl[i].exp);
        end

        // Async reset mid-cycle, then a write edge while held in reset.
        @(posedge clk);
        #3;
        clr = 1'b0;
        #1;
        check("async_clr", BusMuxIn, 32'h0);
        do_op(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, "in_reset");
        check("in_reset_hold", BusMuxIn, 32'h0);
        #3;
        clr = 1'b1;
        do_op(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "post_rel");
        check("post_rel_zero", BusMuxIn, 32'h0);
        do_op(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "rd_after_rst");
        check("rd_after_rst", BusMuxIn, 32'h1234_5678);
        do_op(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, "wr_in_rst");
        check("wr_in_rst", BusMuxIn, 32'hCAFE_F00D);

        // Full sweep: back-to-back writes, then back-to-back reads.
        for (int a = 0; a < 512; a++) begin
            do_op(1'b0, 1'b1, 32'(a), 32'(a) ^ 32'hA5A5_0000, 1'b0, "sweep_wr");
        end
        for (int a = 0; a < 512; a++) begin
            do_op(1'b1, 1'b0, 32'(a), 32'h0, 1'b0, "sweep_rd");
            check("sweep_rd", BusMuxIn, 32'(a) ^ 32'hA5A5_0000);
        end

        // Random traffic with full 32-bit addresses to exercise aliasing.
        for (int n = 0; n < 3000; n++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom(), $urandom(), 1'b1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
